// File: rtl/lfsr_pkg.sv
// Shared types, default sizes and the LFSR step function.
// Used by the LFSR generator and by lfsr_stream_checker.
package lfsr_pkg;

  typedef enum logic [1:0] {SEED, HUNT, LOCKED} chk_state_t;

  localparam int LFSR_W          = 8;
  localparam int LOCK_THRESH_D   = 16;
  localparam int UNLOCK_THRESH_D = 4;

  // Newest bit enters at [0]; feedback is the parity of the tapped history.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] hist,
                                                  input logic [LFSR_W-1:0] tap);
    return {hist[LFSR_W-2:0], ^(hist & tap)};
  endfunction

endpackage

// File: rtl/lfsr_predictor.sv
// History register and registered tap mask.
// Produces the next expected stream bit; load_pred selects predicted vs received bit.
module lfsr_predictor
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             load_pred,
  input  logic             din_bit,
  input  logic [WIDTH-1:0] tap,
  output logic             pred
);

  logic [WIDTH-1:0] hist_q, hist_d;
  logic [WIDTH-1:0] tap_q, tap_d;

  always_comb begin
    pred   = ^(hist_q & tap_q);
    tap_d  = tap;
    hist_d = hist_q;
    if (en) hist_d = {hist_q[WIDTH-2:0], (load_pred ? pred : din_bit)};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q <= '0;
      tap_q  <= '0;
    end else begin
      hist_q <= hist_d;
      tap_q  <= tap_d;
    end
  end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising LFSR stream checker: SEED -> HUNT -> LOCKED with error counting.
// Optional LFSR_CHK_LOSS_CNT_EN adds an 8-bit saturating lock-loss counter output.
module lfsr_stream_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH         = LFSR_W,
  parameter int LOCK_THRESH   = LOCK_THRESH_D,
  parameter int UNLOCK_THRESH = UNLOCK_THRESH_D,
  parameter int ERR_W         = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             din_valid,
  input  logic             din_bit,
  input  logic [WIDTH-1:0] tap,
  input  logic             clr,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sticky
`ifdef LFSR_CHK_LOSS_CNT_EN
  ,output logic [7:0]      loss_cnt
`endif
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_THRESH + 1);
  localparam int UW = $clog2(UNLOCK_THRESH + 1);

  chk_state_t       state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [UW-1:0]    miss_q, miss_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             sticky_q, sticky_d;
  logic             locked_q, locked_d;
  logic             load_pred, pred, hit;
`ifdef LFSR_CHK_LOSS_CNT_EN
  logic [7:0]       loss_q, loss_d;
`endif

  lfsr_predictor #(.WIDTH(WIDTH)) u_pred (
    .clk      (clk),
    .resetn   (resetn),
    .en       (din_valid),
    .load_pred(load_pred),
    .din_bit  (din_bit),
    .tap      (tap),
    .pred     (pred)
  );

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    match_d   = match_q;
    miss_d    = miss_q;
    err_d     = err_q;
    sticky_d  = sticky_q;
    load_pred = 1'b0;
`ifdef LFSR_CHK_LOSS_CNT_EN
    loss_d    = loss_q;
`endif
    hit       = (din_bit == pred);
    if (din_valid) begin
      unique case (state_q)
        SEED: begin
          fill_d = fill_q + 1'b1;
          if (fill_q == FW'(WIDTH - 1)) begin
            state_d = HUNT;
            fill_d  = '0;
            match_d = '0;
          end
        end
        HUNT: begin
          if (!hit) begin
            match_d = '0;
          end else if (match_q == MW'(LOCK_THRESH - 1)) begin
            state_d = LOCKED;
            match_d = '0;
            miss_d  = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        LOCKED: begin
          // Flywheel on our own prediction so isolated errors do not corrupt history.
          load_pred = 1'b1;
          if (hit) begin
            miss_d = '0;
          end else begin
            if (err_q != '1) err_d = err_q + 1'b1;
            sticky_d = 1'b1;
            if (miss_q == UW'(UNLOCK_THRESH - 1)) begin
              state_d = HUNT;
              match_d = '0;
              miss_d  = '0;
`ifdef LFSR_CHK_LOSS_CNT_EN
              if (loss_q != '1) loss_d = loss_q + 1'b1;
`endif
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: state_d = SEED;
      endcase
    end
    if (clr) begin
      err_d    = '0;
      sticky_d = 1'b0;
`ifdef LFSR_CHK_LOSS_CNT_EN
      loss_d   = '0;
`endif
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= SEED;
      fill_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      err_q    <= '0;
      sticky_q <= 1'b0;
      locked_q <= 1'b0;
`ifdef LFSR_CHK_LOSS_CNT_EN
      loss_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      locked_q <= locked_d;
`ifdef LFSR_CHK_LOSS_CNT_EN
      loss_q   <= loss_d;
`endif
    end
  end

  assign locked     = locked_q;
  assign err_cnt    = err_q;
  assign err_sticky = sticky_q;
`ifdef LFSR_CHK_LOSS_CNT_EN
  assign loss_cnt   = loss_q;
`endif

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Randomised bench for lfsr_stream_checker against a queue-based behavioural model.
// Build with +define+LFSR_CHK_LOSS_CNT_EN to also check loss_cnt.
module tb_lfsr_stream_checker;
  import lfsr_pkg::*;

  localparam logic [7:0] GEN_TAP = 8'hB8;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       din_valid = 1'b0;
  logic       din_bit = 1'b0;
  logic [7:0] tap = GEN_TAP;
  logic       clr = 1'b0;
  logic       locked;
  logic [15:0] err_cnt;
  logic       err_sticky;
`ifdef LFSR_CHK_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  always #5 clk = ~clk;

  lfsr_stream_checker dut (
    .clk       (clk),
    .resetn    (resetn),
    .din_valid (din_valid),
    .din_bit   (din_bit),
    .tap       (tap),
    .clr       (clr),
    .locked    (locked),
    .err_cnt   (err_cnt),
    .err_sticky(err_sticky)
`ifdef LFSR_CHK_LOSS_CNT_EN
    ,.loss_cnt (loss_cnt)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: history as a queue of shifted bits, newest first.
  bit         mh[$];
  int         m_mode, m_fill, m_match, m_miss, m_err, m_loss;
  bit         m_sticky;
  logic [7:0] m_tap;
  logic [7:0] gen_q = 8'h01;
  logic [7:0] cur_tap = GEN_TAP;
  int         vcount = 0;

  task automatic model_reset();
    mh.delete();
    m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0;
    m_err = 0; m_loss = 0; m_sticky = 0; m_tap = 8'h00;
  endtask

  task automatic model_step(input bit v, input bit b, input bit c, input logic [7:0] t);
    bit p;
    p = 1'b0;
    for (int i = 0; i < 8; i++)
      if (m_tap[i] && i < mh.size()) p ^= mh[i];
    if (v) begin
      if (m_mode == 0) begin
        mh.push_front(b);
        m_fill++;
        if (m_fill == 8) begin m_mode = 1; m_match = 0; end
      end else if (m_mode == 1) begin
        mh.push_front(b);
        m_match = (b == p) ? m_match + 1 : 0;
        if (m_match == 16) begin m_mode = 2; m_match = 0; m_miss = 0; end
      end else begin
        mh.push_front(p);
        if (b != p) begin
          if (m_err < 65535) m_err++;
          m_sticky = 1'b1;
          m_miss++;
          if (m_miss == 4) begin
            m_mode = 1; m_miss = 0; m_match = 0;
            if (m_loss < 255) m_loss++;
          end
        end else begin
          m_miss = 0;
        end
      end
      while (mh.size() > 8) void'(mh.pop_back());
    end
    if (c) begin m_err = 0; m_sticky = 1'b0; m_loss = 0; end
    m_tap = t;
  endtask

  task automatic check_all();
    chk("locked", {31'd0, locked}, {31'd0, (m_mode == 2)});
    chk("err_cnt", {16'd0, err_cnt}, m_err);
    chk("err_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
`ifdef LFSR_CHK_LOSS_CNT_EN
    chk("loss_cnt", {24'd0, loss_cnt}, m_loss);
`endif
  endtask

  task automatic step(input bit v, input bit inv, input bit c);
    bit b;
    @(negedge clk);
    b = v ? (gen_q[0] ^ inv) : 1'($urandom);
    din_valid = v; din_bit = b; clr = c; tap = cur_tap;
    @(posedge clk);
    model_step(v, b, c, cur_tap);
    if (v) begin
      gen_q = lfsr_next(gen_q, GEN_TAP);
      vcount++;
    end
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    din_valid = 1'b0; clr = 1'b0;
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    m_tap = cur_tap;
    vcount = 0;
  endtask

  initial begin
    int guard;
    #3;
    do_reset();

    // Clean lock from the generator seed, then a long error-free run.
    for (int k = 1; k <= 1000; k++) begin
      step(1, 0, 0);
      if (k == 23) chk("lock_bit23", {31'd0, locked}, 32'd0);
      if (k == 24) chk("lock_bit24", {31'd0, locked}, 32'd1);
    end
    chk("clean_err", {16'd0, err_cnt}, 32'd0);

    // Single error stays locked and does not propagate.
    step(1, 1, 0);
    chk("single_err", {16'd0, err_cnt}, 32'd1);
    chk("single_sticky", {31'd0, err_sticky}, 32'd1);
    chk("single_locked", {31'd0, locked}, 32'd1);
    for (int k = 0; k < 100; k++) step(1, 0, 0);
    chk("single_after", {16'd0, err_cnt}, 32'd1);

    // clr wins over a simultaneous mismatch.
    step(1, 1, 1);
    chk("clr_err", {16'd0, err_cnt}, 32'd0);
    chk("clr_sticky", {31'd0, err_sticky}, 32'd0);
    for (int k = 0; k < 5; k++) step(1, 0, 0);

    // Burst of four errors drops lock; relock 16 clean bits later.
    for (int k = 1; k <= 4; k++) begin
      step(1, 1, 0);
      if (k == 3) chk("burst_hold", {31'd0, locked}, 32'd1);
    end
    chk("burst_err", {16'd0, err_cnt}, 32'd4);
    chk("burst_unlock", {31'd0, locked}, 32'd0);
`ifdef LFSR_CHK_LOSS_CNT_EN
    chk("burst_loss", {24'd0, loss_cnt}, 32'd1);
`endif
    for (int k = 1; k <= 16; k++) begin
      step(1, 0, 0);
      if (k == 15) chk("relock_15", {31'd0, locked}, 32'd0);
      if (k == 16) chk("relock_16", {31'd0, locked}, 32'd1);
    end

    // Wrong tap mask, then restore.
    cur_tap = 8'h8E;
    for (int k = 0; k < 60; k++) step(1, 0, 0);
    cur_tap = GEN_TAP;
    for (int k = 0; k < 400; k++) step(1, 0, 0);
    chk("tap_relock", {31'd0, locked}, 32'd1);

    // Random gaps from reset: lock exactly on valid bit 24.
    do_reset();
    guard = 0;
    while (vcount < 24 && guard < 1000) begin
      bit v;
      v = 1'($urandom);
      step(v, 0, 0);
      if (v && vcount == 23) chk("gap_bit23", {31'd0, locked}, 32'd0);
      guard++;
    end
    chk("gap_bit24", {31'd0, locked}, 32'd1);
    for (int k = 0; k < 200; k++) step(1'($urandom), 0, 0);
    chk("gap_err", {16'd0, err_cnt}, 32'd0);

    // Reset mid-lock, full reacquire.
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      step(1, 0, 0);
      if (k == 23) chk("reacq_23", {31'd0, locked}, 32'd0);
    end
    chk("reacq_24", {31'd0, locked}, 32'd1);

    // Random valid, sparse bit errors and clears against the model.
    for (int k = 0; k < 3000; k++)
      step(($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 100) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
